// File: rtl/baccarat_datapath.sv
// Baccarat dealing datapath: free-running deck counter, six card slots,
// registered hand scores and sticky protocol-violation flags.
module baccarat_datapath #(
  parameter int DECK_MIN = 1,
  parameter int DECK_MAX = 13
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] deal_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       dup_load_err,
  output logic       multi_load_err
);

  localparam logic [3:0] DECK_LO = 4'(DECK_MIN);
  localparam logic [3:0] DECK_HI = 4'(DECK_MAX);

  // Baccarat point value of a rank; face cards, tens and empty slots are 0.
  function automatic logic [4:0] card_value(input logic [3:0] rank);
    card_value = (rank <= 4'd9) ? {1'b0, rank} : 5'd0;
  endfunction

  // Sum of three values is at most 27, so two conditional subtractions suffice.
  function automatic logic [3:0] mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20)      r = sum - 5'd20;
    else if (sum >= 5'd10) r = sum - 5'd10;
    else                   r = sum;
    mod10 = r[3:0];
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    hand_score = mod10(card_value(c1) + card_value(c2) + card_value(c3));
  endfunction

  // Slot order doubles as priority order: bit 0 (pcard1) is highest.
  logic [5:0] load_vec;
  logic [5:0] win_vec;
  logic [5:0] empty_vec;
  logic [3:0] card_q [6];
  logic [3:0] card_d [6];
  logic       accept;
  logic       dup_hit;
  logic       multi_hit;
  logic [3:0] deck_next;

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

  always_comb begin
    win_vec   = load_vec & (~load_vec + 6'd1);
    multi_hit = (load_vec & (load_vec - 6'd1)) != 6'd0;
    for (int i = 0; i < 6; i++) begin
      empty_vec[i] = (card_q[i] == 4'd0);
      card_d[i]    = card_q[i];
      if (win_vec[i] && empty_vec[i]) card_d[i] = deal_card;
    end
    accept    = |(win_vec & empty_vec);
    dup_hit   = |(win_vec & ~empty_vec);
    deck_next = (deal_card == DECK_HI) ? DECK_LO : deal_card + 4'd1;
  end

  // Register stage: cards and scores are written on the same edge.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) card_q[i] <= 4'd0;
      pscore         <= 4'd0;
      dscore         <= 4'd0;
      cards_dealt    <= 3'd0;
      dup_load_err   <= 1'b0;
      multi_load_err <= 1'b0;
      deal_card      <= DECK_LO;
    end else begin
      for (int i = 0; i < 6; i++) card_q[i] <= card_d[i];
      pscore    <= hand_score(card_d[0], card_d[1], card_d[2]);
      dscore    <= hand_score(card_d[3], card_d[4], card_d[5]);
      deal_card <= deck_next;
      if (accept)    cards_dealt    <= cards_dealt + 3'd1;
      if (dup_hit)   dup_load_err   <= 1'b1;
      if (multi_hit) multi_load_err <= 1'b1;
    end
  end

  assign pcard1 = card_q[0];
  assign pcard2 = card_q[1];
  assign pcard3 = card_q[2];
  assign dcard1 = card_q[3];
  assign dcard2 = card_q[4];
  assign dcard3 = card_q[5];

endmodule
